// File: rtl/wb_bridge_pkg.sv
// Shared state type and default widths for the Wishbone-to-device bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } wb_bridge_state_e;

  localparam int unsigned DefDataWidth      = 32;
  localparam int unsigned DefAddressWidth   = 32;
  localparam int unsigned DefMaxOutstanding = 2;
  localparam int unsigned DefTimeoutCycles  = 64;

endpackage

// File: rtl/wb_device_bridge_if.sv
// Crossbar-side Wishbone slave port plus device req/rvalid port of one bridge.
// slave = bridge view; master = the crossbar and device surrounding it.
interface wb_device_bridge_if
  import wb_bridge_pkg::*;
#(
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned AddressWidth = DefAddressWidth
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [AddressWidth-1:0] wb_addr_i;
  logic [DataWidth-1:0]    wb_data_i;
  logic [BeWidth-1:0]      wb_sel_i;
  logic                    wb_stall_o;
  logic                    wb_ack_o;
  logic [DataWidth-1:0]    wb_data_o;
  logic                    wb_err_o;

  logic                    device_req_o;
  logic [AddressWidth-1:0] device_addr_o;
  logic                    device_we_o;
  logic [BeWidth-1:0]      device_be_o;
  logic [DataWidth-1:0]    device_wdata_o;
  logic                    device_rvalid_i;
  logic [DataWidth-1:0]    device_rdata_i;
  logic                    device_err_i;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
    output wb_stall_o, wb_ack_o, wb_data_o, wb_err_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_rdata_i, device_err_i
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
    input  wb_stall_o, wb_ack_o, wb_data_o, wb_err_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_rdata_i, device_err_i
  );

endinterface

// File: rtl/wb_device_bridge.sv
// Wishbone pipelined slave to Ibex-style device adapter; WB_DEVICE_BRIDGE_TIMEOUT_EN adds a silent-device timeout.
// Latency: accept at N, device rvalid at N+1, ack/err at N+2 (response registered, request combinational).
// Backpressure: stall while MaxOutstanding requests are unanswered, while draining, and for one cycle out of reset.
module wb_device_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned DataWidth      = DefDataWidth,
  parameter int unsigned AddressWidth   = DefAddressWidth,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding,
  parameter int unsigned TimeoutCycles  = DefTimeoutCycles
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  wb_device_bridge_if.slave       bus
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  typedef logic [CntW-1:0] cnt_t;

  wb_bridge_state_e     state_q, state_d;
  cnt_t                 cnt_q, cnt_d;
  logic                 rst_done_q;
  logic                 ack_q, err_q;
  logic [DataWidth-1:0] data_q;
  logic                 at_limit, accept, counted_rvalid, resp_en, timeout_hit;

  assign at_limit       = (cnt_q == cnt_t'(MaxOutstanding));
  // Stall depends only on state and rvalid, never on wb_stb_i.
  assign bus.wb_stall_o = ~rst_done_q | (state_q == DRAIN) | (at_limit & ~bus.device_rvalid_i);
  assign accept         = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_stall_o & (state_q != DRAIN);
  assign counted_rvalid = bus.device_rvalid_i & (cnt_q != '0);
  assign resp_en        = counted_rvalid & bus.wb_cyc_i & (state_q != DRAIN);

  assign bus.device_req_o   = accept;
  assign bus.device_addr_o  = bus.wb_addr_i;
  assign bus.device_we_o    = bus.wb_we_i;
  assign bus.device_be_o    = bus.wb_sel_i;
  assign bus.device_wdata_o = bus.wb_data_i;

  assign bus.wb_ack_o  = ack_q;
  assign bus.wb_err_o  = err_q;
  assign bus.wb_data_o = data_q;

`ifdef WB_DEVICE_BRIDGE_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
  logic [TimerW-1:0] timer_q;

  // timer_q counts cycles since the last accept/rvalid, that cycle included.
  assign timeout_hit = (cnt_q != '0) & ~accept & ~bus.device_rvalid_i &
                       (timer_q == TimerW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else if (accept | bus.device_rvalid_i) begin
      timer_q <= TimerW'(1);
    end else if (timeout_hit) begin
      timer_q <= '0;
    end else if (cnt_q != '0) begin
      timer_q <= timer_q + TimerW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (accept & ~counted_rvalid) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (~accept & counted_rvalid) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE: begin
        if (cnt_d == '0)       state_d = IDLE;
        else if (~bus.wb_cyc_i) state_d = DRAIN;
      end
      DRAIN:   if (cnt_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_done_q <= 1'b1;
    end
  end

  // Responses are dropped outside the crossbar's cycle and while draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q <= resp_en & ~bus.device_err_i;
      err_q <= (resp_en & bus.device_err_i) | (timeout_hit & bus.wb_cyc_i);
      if (resp_en) data_q <= bus.device_rdata_i;
    end
  end

endmodule

// File: tb/tb_wb_device_bridge.sv
// Randomized bench for wb_device_bridge against a transaction-level model with an in-order device queue.
module tb_wb_device_bridge;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MAX = 2;
  localparam int TO  = 8;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_device_bridge_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();

  wb_device_bridge #(
    .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MAX), .TimeoutCycles(TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  logic        cyc_d = 0, stb_d = 0, we_d = 0;
  logic [31:0] addr_d = 0, wdata_d = 0;
  logic [3:0]  sel_d = 0;
  int          lat_min = 1, lat_max = 1, err_pct = 0;
  bit          force_en = 0, dev_silent = 0, stray_now = 0;
  logic [31:0] force_val = 0;
  rsp_t        dev_q[$];

  // reference model
  int          pend = 0;
  bit          drain = 0, released = 0;
  int          last_evt = 0;
  logic        exp_ack = 0, exp_err = 0;
  logic [31:0] exp_data = 0;
  int          cyc_no = 0;

  // observations
  bit          last_acc = 0;
  int          n_ack, n_err, n_stall, run, max_run, ack_cyc, err_cyc;
  logic [31:0] last_ack_data;
  int          acc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  task automatic clear_tally();
    n_ack = 0; n_err = 0; n_stall = 0; run = 0; max_run = 0;
    ack_cyc = -1; err_cyc = -1; last_ack_data = 0;
    acc_q.delete();
  endtask

  task automatic step();
    logic        rv, rerr, e_stall, e_req, cnt_rv, resp;
    logic [31:0] rdat;
    int          pend_n;
    rsp_t        r;
    @(posedge clk);
    if (rst_n) released = 1;
    #1;
    cyc_no++;
    rv = 0; rerr = 1'($urandom); rdat = $urandom;
    if (dev_q.size() > 0 && dev_q[0].due <= cyc_no) begin
      r = dev_q.pop_front();
      rv = 1; rdat = r.rdata; rerr = r.err;
    end else if (stray_now) begin
      rv = 1; rerr = 0;
    end
    stray_now = 0;
    bus.wb_cyc_i = cyc_d;  bus.wb_stb_i = stb_d;  bus.wb_we_i = we_d;
    bus.wb_addr_i = addr_d; bus.wb_data_i = wdata_d; bus.wb_sel_i = sel_d;
    bus.device_rvalid_i = rv; bus.device_rdata_i = rdat; bus.device_err_i = rerr;
    @(negedge clk);

    e_stall = !released || drain || (pend == MAX && !rv);
    e_req   = cyc_d && stb_d && !e_stall;
    check("stall", bus.wb_stall_o, e_stall);
    check("req", bus.device_req_o, e_req);
    check("ack", bus.wb_ack_o, exp_ack);
    check("err", bus.wb_err_o, exp_err);
    check("rdata", bus.wb_data_o, exp_data);
    if (e_req) begin
      check("dev_addr", bus.device_addr_o, addr_d);
      check("dev_we", bus.device_we_o, we_d);
      check("dev_be", bus.device_be_o, sel_d);
      check("dev_wdata", bus.device_wdata_o, wdata_d);
    end

    last_acc = bus.device_req_o;
    if (last_acc) acc_q.push_back(cyc_no);
    if (bus.wb_stall_o) n_stall++;
    if (bus.wb_err_o) begin n_err++; err_cyc = cyc_no; end
    if (bus.wb_ack_o) begin
      n_ack++; ack_cyc = cyc_no; last_ack_data = bus.wb_data_o; run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (last_acc && !dev_silent) begin
      r.due   = cyc_no + $urandom_range(lat_max, lat_min);
      r.rdata = force_en ? force_val : $urandom;
      r.err   = ($urandom_range(99) < err_pct);
      dev_q.push_back(r);
    end

    cnt_rv   = rv && pend > 0;
    resp     = cnt_rv && cyc_d && !drain;
    exp_ack  = resp && !rerr;
    exp_err  = resp && rerr;
    if (resp) exp_data = rdat;
    pend_n = pend + int'(e_req) - int'(cnt_rv);
    if (e_req || cnt_rv) last_evt = cyc_no;
`ifdef WB_DEVICE_BRIDGE_TIMEOUT_EN
    else if (pend > 0 && cyc_no - last_evt == TO - 1) begin
      exp_err = cyc_d;
      pend_n  = 0;
    end
`endif
    drain = (drain || !cyc_d) && pend_n > 0;
    pend  = pend_n;
  endtask

  task automatic issue(input int n, input logic we, input logic [31:0] base);
    int got = 0;
    int budget = 60;
    cyc_d = 1; stb_d = 1; we_d = we; addr_d = base; wdata_d = $urandom; sel_d = 4'hF;
    while (got < n && budget > 0) begin
      step();
      budget--;
      if (last_acc) begin
        got++;
        addr_d = base + 32'(4 * got); wdata_d = $urandom; sel_d = 4'($urandom);
      end
    end
    stb_d = 0;
    check("issue_done", got, n);
  endtask

  task automatic settle();
    cyc_d = 0; stb_d = 0;
    repeat (6) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
    rst_n = 0;
    #1;
    check("rst_stall", bus.wb_stall_o, 1);
    check("rst_ack", bus.wb_ack_o, 0);
    check("rst_err", bus.wb_err_o, 0);
    check("rst_data", bus.wb_data_o, 0);
    check("rst_req", bus.device_req_o, 0);
    pend = 0; drain = 0; released = 0; exp_ack = 0; exp_err = 0; exp_data = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("rel_stall", bus.wb_stall_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle %0d", cyc_no);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_addr_i = 0;
    bus.wb_data_i = 0; bus.wb_sel_i = 0;
    bus.device_rvalid_i = 0; bus.device_rdata_i = 0; bus.device_err_i = 0;
    do_reset();
    clear_tally();

    // single read, 0xDEADBEEF one cycle after the request
    lat_min = 1; lat_max = 1; force_en = 1; force_val = 32'hDEADBEEF;
    issue(1, 0, 32'h100);
    repeat (3) step();
    check("rd_acks", n_ack, 1);
    check("rd_errs", n_err, 0);
    check("rd_data", last_ack_data, 32'hDEADBEEF);
    check("rd_lat", ack_cyc - acc_q[0], 2);
    force_en = 0;
    settle();

    // four back-to-back writes at full rate
    clear_tally();
    issue(4, 1, 32'h1000);
    repeat (3) step();
    check("b2b_stall", n_stall, 0);
    check("b2b_acks", n_ack, 4);
    check("b2b_run", max_run, 4);
    settle();

    // slow device: third request waits for the first rvalid
    clear_tally();
    lat_min = 3; lat_max = 3;
    issue(3, 0, 32'h2000);
    repeat (6) step();
    check("slow_third", acc_q[2] - acc_q[0], 3);
    check("slow_stall", n_stall, 1);
    check("slow_acks", n_ack, 3);
    settle();

    // error response
    clear_tally();
    lat_min = 1; lat_max = 1; err_pct = 100;
    issue(1, 0, 32'h3000);
    repeat (3) step();
    check("derr_errs", n_err, 1);
    check("derr_acks", n_ack, 0);
    err_pct = 0;
    settle();

    // cycle abort with two outstanding, then a new request must wait out the drain
    clear_tally();
    lat_min = 3; lat_max = 3;
    issue(2, 1, 32'h4000);
    cyc_d = 0; stb_d = 0;
    step();
    issue(1, 0, 32'h5000);
    check("drain_acks", n_ack, 0);
    check("drain_errs", n_err, 0);
    check("drain_acc", acc_q[2] - acc_q[0], 5);
    check("drain_stall", n_stall, 3);
    repeat (6) step();
    settle();

    // reset mid-transaction, the late rvalid is stray
    issue(1, 0, 32'h6000);
    step();
    do_reset();
    clear_tally();
    cyc_d = 1;
    repeat (5) step();
    check("rstmid_acks", n_ack, 0);
    check("rstmid_errs", n_err, 0);
    settle();

`ifdef WB_DEVICE_BRIDGE_TIMEOUT_EN
    // silent device times out, a later stray rvalid is ignored
    clear_tally();
    dev_silent = 1;
    issue(1, 0, 32'h7000);
    repeat (12) step();
    check("to_errs", n_err, 1);
    check("to_lat", err_cyc - acc_q[0], TO);
    dev_silent = 0;
    stray_now = 1;
    repeat (3) step();
    check("to_stray_acks", n_ack, 0);
    settle();
`endif

    // random bursts with aborts, varying latency and errors
    for (int b = 0; b < 60; b++) begin
      lat_min = 1; lat_max = $urandom_range(4, 1); err_pct = 15;
      cyc_d = 1;
      for (int i = 0; i < int'($urandom_range(40, 5)); i++) begin
        if (!stb_d || last_acc) begin
          stb_d = ($urandom_range(99) < 60); we_d = 1'($urandom);
          addr_d = $urandom; wdata_d = $urandom; sel_d = 4'($urandom);
        end
        step();
      end
      cyc_d = 0; stb_d = 0;
      repeat ($urandom_range(6, 0)) step();
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
